// File: rtl/ahbmm_pkg.sv
// Shared types and sizing helpers for the AHB multi-manager interconnect.
package ahbmm_pkg;

    typedef enum logic {GD_IDLE, GD_GRANTED} grantstate_t;

    // Index width for a manager count; at least one bit even for degenerate counts.
    function automatic int unsigned idx_width(int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned DefaultWidth = 4;
    localparam int unsigned DefaultIdxW  = idx_width(DefaultWidth);

endpackage

// File: rtl/bintoonehot.sv
// Combinational binary index to one-hot decoder; all-zero when disabled or out of range.
module bintoonehot import ahbmm_pkg::*; #(
    parameter  int unsigned WIDTH = DefaultWidth,
    localparam int unsigned IDXW  = idx_width(WIDTH)
) (
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [WIDTH-1:0] oh
);

    always_comb begin
        oh = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            oh[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/ahb_grant_decoder.sv
// Registered one-hot address-phase grant plus HREADY-delayed data-phase owner.
// Optional forced release after TIMEOUT cycles when GRANT_TIMEOUT_EN is defined.
module ahb_grant_decoder import ahbmm_pkg::*; #(
    parameter  int unsigned WIDTH   = DefaultWidth,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned IDXW    = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDXW-1:0]  IndexIn,
    input  logic             IndexValid,
    input  logic             Release,
    input  logic             HREADY,
    output logic             Accept,
    output logic             IndexErr,
    output logic [WIDTH-1:0] GrantOH,
    output logic [WIDTH-1:0] DataOwnerOH,
    output logic             Busy,
    output logic             Timeout
);

    if (WIDTH < 2 || TIMEOUT < 2) begin : g_cfg_check
        $error("ahb_grant_decoder: WIDTH and TIMEOUT must both be >= 2");
    end

    grantstate_t      state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] onehot;
    logic             valid;
    logic             free;
    logic             expire;

    assign valid    = IndexValid && (32'(IndexIn) < WIDTH);
    assign IndexErr = IndexValid && !valid;

    // The grant slot is free when idle, or when the owner hands over on an HREADY cycle.
    assign free   = (state_q == GD_IDLE) ||
                    ((state_q == GD_GRANTED) && ((Release && HREADY) || expire));
    assign Accept = valid && free;

    bintoonehot #(
        .WIDTH (WIDTH)
    ) u_bintoonehot (
        .idx (IndexIn),
        .en  (valid),
        .oh  (onehot)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (free) begin
            grant_d = onehot;
            state_d = valid ? GD_GRANTED : GD_IDLE;
        end
    end

    assign data_d = HREADY ? grant_q : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GD_IDLE;
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Accept) begin
            cnt_d = '0;
        end else if ((state_q == GD_GRANTED) && (cnt_q < CntW'(TIMEOUT))) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Only fires with HREADY high so a stalled transfer is never cut short.
    assign expire    = (state_q == GD_GRANTED) && HREADY && (cnt_q >= CntW'(TIMEOUT - 1));
    assign timeout_d = expire && !Release;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign Timeout = 1'b0;
`endif

    assign GrantOH     = grant_q;
    assign DataOwnerOH = data_q;
    assign Busy        = (state_q == GD_GRANTED);

endmodule

// File: tb/tb_ahb_grant_decoder.sv
// Directed self-checking bench for ahb_grant_decoder (WIDTH=4 and WIDTH=3 instances).
module tb_ahb_grant_decoder;

    logic clk = 1'b0;
    logic reset;

    logic [1:0] ii;
    logic       iv, rel, hr;
    logic       acc, ierr, busy, tmo;
    logic [3:0] gnt, down;

    logic [1:0] ii3;
    logic       iv3, rel3, hr3;
    logic       acc3, ierr3, busy3, tmo3;
    logic [2:0] gnt3, down3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_grant_decoder #(
        .WIDTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .IndexIn     (ii),
        .IndexValid  (iv),
        .Release     (rel),
        .HREADY      (hr),
        .Accept      (acc),
        .IndexErr    (ierr),
        .GrantOH     (gnt),
        .DataOwnerOH (down),
        .Busy        (busy),
        .Timeout     (tmo)
    );

    ahb_grant_decoder #(
        .WIDTH   (3),
        .TIMEOUT (16)
    ) dut3 (
        .clk         (clk),
        .reset       (reset),
        .IndexIn     (ii3),
        .IndexValid  (iv3),
        .Release     (rel3),
        .HREADY      (hr3),
        .Accept      (acc3),
        .IndexErr    (ierr3),
        .GrantOH     (gnt3),
        .DataOwnerOH (down3),
        .Busy        (busy3),
        .Timeout     (tmo3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ii = '0; iv = 1'b0; rel = 1'b0; hr = 1'b1;
        ii3 = '0; iv3 = 1'b0; rel3 = 1'b0; hr3 = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(gnt), 32'h0);
        chk("rst_data", 32'(down), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(tmo), 32'h0);
        reset = 1'b0;
        tick();

        // 1: grant index 2 from idle
        iv = 1'b1; ii = 2'd2;
        #1;
        chk("t1_accept", 32'(acc), 32'h1);
        chk("t1_ierr", 32'(ierr), 32'h0);
        tick();
        iv = 1'b0;
        chk("t1_grant", 32'(gnt), 32'h4);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_data_lag", 32'(down), 32'h0);
        tick();
        chk("t1_data", 32'(down), 32'h4);
        chk("t1_hold", 32'(gnt), 32'h4);

        // 2: back-to-back handover to index 0
        rel = 1'b1; iv = 1'b1; ii = 2'd0;
        #1;
        chk("t2_accept", 32'(acc), 32'h1);
        tick();
        chk("t2_grant", 32'(gnt), 32'h1);
        chk("t2_busy", 32'(busy), 32'h1);
        chk("t2_data_lag", 32'(down), 32'h4);

        // 3: release while stalled is ignored, data owner frozen
        hr = 1'b0; rel = 1'b1; iv = 1'b1; ii = 2'd3;
        #1;
        chk("t3_no_accept", 32'(acc), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_grant_hold", 32'(gnt), 32'h1);
            chk("t3_data_frozen", 32'(down), 32'h4);
        end
        rel = 1'b0; iv = 1'b0; hr = 1'b1;
        tick();
        chk("t3_not_remembered", 32'(gnt), 32'h1);
        chk("t3_data_resume", 32'(down), 32'h1);
        chk("t3_busy", 32'(busy), 32'h1);

        // 4: out-of-range index on WIDTH=3
        iv3 = 1'b1; ii3 = 2'd3;
        #1;
        chk("t4_ierr", 32'(ierr3), 32'h1);
        chk("t4_no_accept", 32'(acc3), 32'h0);
        tick();
        chk("t4_grant", 32'(gnt3), 32'h0);
        chk("t4_busy", 32'(busy3), 32'h0);
        ii3 = 2'd2;
        #1;
        chk("t4_legal_accept", 32'(acc3), 32'h1);
        chk("t4_legal_ierr", 32'(ierr3), 32'h0);
        tick();
        chk("t4_legal_grant", 32'(gnt3), 32'h4);
        ii3 = 2'd3;
        #1;
        chk("t4_ierr_granted", 32'(ierr3), 32'h1);
        iv3 = 1'b0;

        // release to idle
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("rel_grant", 32'(gnt), 32'h0);
        chk("rel_busy", 32'(busy), 32'h0);
        chk("rel_data_lag", 32'(down), 32'h1);
        tick();
        chk("rel_data", 32'(down), 32'h0);

        // re-grant of the same index
        iv = 1'b1; ii = 2'd1;
        tick();
        chk("same_first", 32'(gnt), 32'h2);
        rel = 1'b1;
        #1;
        chk("same_accept", 32'(acc), 32'h1);
        tick();
        rel = 1'b0; iv = 1'b0;
        chk("same_grant", 32'(gnt), 32'h2);
        chk("same_busy", 32'(busy), 32'h1);
        tick();
        chk("same_data", 32'(down), 32'h2);

        // 5: asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("t5_grant", 32'(gnt), 32'h0);
        chk("t5_data", 32'(down), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        chk("t5_no_replay", 32'(gnt), 32'h0);

        // 6: long hold on index 3
        iv = 1'b1; ii = 2'd3; hr = 1'b1; rel = 1'b0;
        tick();
        iv = 1'b0;
        chk("t6_grant", 32'(gnt), 32'h8);
`ifdef GRANT_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t6_pre_expiry", 32'(gnt), 32'h8);
            chk("t6_no_pulse", 32'(tmo), 32'h0);
        end
        tick();
        chk("t6_expired", 32'(gnt), 32'h0);
        chk("t6_pulse", 32'(tmo), 32'h1);
        tick();
        chk("t6_pulse_end", 32'(tmo), 32'h0);
        chk("t6_idle", 32'(busy), 32'h0);

        // expiry during a stall waits for HREADY
        iv = 1'b1; ii = 2'd3;
        tick();
        iv = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        hr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6s_stalled_hold", 32'(gnt), 32'h8);
            chk("t6s_no_pulse", 32'(tmo), 32'h0);
        end
        hr = 1'b1;
        tick();
        chk("t6s_expired", 32'(gnt), 32'h0);
        chk("t6s_pulse", 32'(tmo), 32'h1);
        tick();
        chk("t6s_pulse_end", 32'(tmo), 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_held", 32'(gnt), 32'h8);
            chk("t6_no_timeout", 32'(tmo), 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
